// File: rtl/ofmap_rd_arbiter_pkg.sv
// rtl/ofmap_rd_arbiter_pkg.sv - shared types for the ofmap BRAM read-port arbiter
package ofmap_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PEND      = 2'd1,
        ST_WAIT_DATA = 2'd2
    } host_state_e;

    typedef struct packed {
        logic valid;
        logic is_host;
    } rd_tag_t;

endpackage

// File: rtl/ofmap_rd_tag_pipe.sv
// rtl/ofmap_rd_tag_pipe.sv - owner-tag shift register matching the BRAM read latency
module ofmap_rd_tag_pipe
    import ofmap_rd_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stages [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/ofmap_rd_arbiter.sv
// rtl/ofmap_rd_arbiter.sv - ofmap BRAM read-port arbiter, controller priority; OFMAP_ARB_OREG_EN adds output register
module ofmap_rd_arbiter
    import ofmap_rd_arbiter_pkg::*;
#(
    parameter int ADDR_WID = 16,
    parameter int DATA_WID = 32,
    parameter int RD_LAT   = 1,
    parameter int WAIT_WID = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                acc_ren,
    input  logic [ADDR_WID-1:0] acc_raddr,
    output logic [DATA_WID-1:0] acc_rdata,
    output logic                acc_rvalid,
    input  logic                host_req,
    input  logic [ADDR_WID-1:0] host_addr,
    output logic                host_gnt,
    output logic [DATA_WID-1:0] host_rdata,
    output logic                host_rvalid,
    output logic                bram_ren,
    output logic [ADDR_WID-1:0] bram_raddr,
    input  logic [DATA_WID-1:0] bram_rdata,
    output logic [WAIT_WID-1:0] host_wait
);

    host_state_e state;
    host_state_e state_nxt;
    rd_tag_t     issue_tag;
    rd_tag_t     tail_tag;
    logic        acc_hit;
    logic        host_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (host_req) begin
                    state_nxt = acc_ren ? ST_PEND : ST_WAIT_DATA;
                end
            end
            ST_PEND: begin
                if (!host_req) begin
                    state_nxt = ST_IDLE;
                end else if (!acc_ren) begin
                    state_nxt = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (host_rvalid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Controller is never stalled; host only fills cycles the controller leaves idle.
    always_comb begin
        bram_ren   = 1'b0;
        bram_raddr = '0;
        host_gnt   = 1'b0;
        if (!rst) begin
            if (acc_ren) begin
                bram_ren   = 1'b1;
                bram_raddr = acc_raddr;
            end else if (host_req && (state == ST_IDLE || state == ST_PEND)) begin
                bram_ren   = 1'b1;
                bram_raddr = host_addr;
                host_gnt   = 1'b1;
            end
        end
    end

    assign issue_tag.valid   = bram_ren;
    assign issue_tag.is_host = host_gnt;

    ofmap_rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (issue_tag),
        .tag_out (tail_tag)
    );

    // Gating with rst drops tags still in flight when reset lands mid-read.
    assign acc_hit  = !rst && tail_tag.valid && !tail_tag.is_host;
    assign host_hit = !rst && tail_tag.valid &&  tail_tag.is_host;

`ifdef OFMAP_ARB_OREG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            acc_rdata   <= '0;
            host_rdata  <= '0;
        end else begin
            acc_rvalid  <= acc_hit;
            host_rvalid <= host_hit;
            if (acc_hit) begin
                acc_rdata <= bram_rdata;
            end
            if (host_hit) begin
                host_rdata <= bram_rdata;
            end
        end
    end
`else
    logic [DATA_WID-1:0] acc_hold;
    logic [DATA_WID-1:0] host_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_hold  <= '0;
            host_hold <= '0;
        end else begin
            if (acc_hit) begin
                acc_hold <= bram_rdata;
            end
            if (host_hit) begin
                host_hold <= bram_rdata;
            end
        end
    end

    assign acc_rvalid  = acc_hit;
    assign host_rvalid = host_hit;
    assign acc_rdata   = acc_hit  ? bram_rdata : acc_hold;
    assign host_rdata  = host_hit ? bram_rdata : host_hold;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            host_wait <= '0;
        end else if (host_req && !host_gnt && host_wait != {WAIT_WID{1'b1}}) begin
            host_wait <= host_wait + 1'b1;
        end
    end

endmodule

// File: tb/tb_ofmap_rd_arbiter.sv
// tb/tb_ofmap_rd_arbiter.sv - directed self-checking bench for ofmap_rd_arbiter
module tb_ofmap_rd_arbiter;

`ifdef OFMAP_ARB_OREG_EN
    localparam int OREG = 1;
`else
    localparam int OREG = 0;
`endif
    localparam int L1 = 1 + OREG;
    localparam int L3 = 3 + OREG;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        acc_ren, host_req;
    logic [15:0] acc_raddr, host_addr;
    logic [31:0] acc_rdata, host_rdata, bram_rdata;
    logic        acc_rvalid, host_gnt, host_rvalid, bram_ren;
    logic [15:0] bram_raddr, host_wait;

    logic [31:0] d4_acc_rdata, d4_host_rdata, d4_bram_rdata;
    logic        d4_acc_rvalid, d4_host_gnt, d4_host_rvalid, d4_bram_ren;
    logic [15:0] d4_bram_raddr;
    logic [3:0]  d4_host_wait;

    logic        a3_ren, h3_req;
    logic [15:0] a3_addr, h3_addr;
    logic [31:0] d3_acc_rdata, d3_host_rdata, d3_bram_rdata;
    logic        d3_acc_rvalid, d3_host_gnt, d3_host_rvalid, d3_bram_ren;
    logic [15:0] d3_bram_raddr, d3_host_wait;

    ofmap_rd_arbiter #(.ADDR_WID(16), .DATA_WID(32), .RD_LAT(1), .WAIT_WID(16)) dut (
        .clk(clk), .rst(rst), .acc_ren(acc_ren), .acc_raddr(acc_raddr), .acc_rdata(acc_rdata),
        .acc_rvalid(acc_rvalid), .host_req(host_req), .host_addr(host_addr), .host_gnt(host_gnt),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid), .bram_ren(bram_ren), .bram_raddr(bram_raddr),
        .bram_rdata(bram_rdata), .host_wait(host_wait));

    ofmap_rd_arbiter #(.ADDR_WID(16), .DATA_WID(32), .RD_LAT(1), .WAIT_WID(4)) dut4 (
        .clk(clk), .rst(rst), .acc_ren(acc_ren), .acc_raddr(acc_raddr), .acc_rdata(d4_acc_rdata),
        .acc_rvalid(d4_acc_rvalid), .host_req(host_req), .host_addr(host_addr), .host_gnt(d4_host_gnt),
        .host_rdata(d4_host_rdata), .host_rvalid(d4_host_rvalid), .bram_ren(d4_bram_ren), .bram_raddr(d4_bram_raddr),
        .bram_rdata(d4_bram_rdata), .host_wait(d4_host_wait));

    ofmap_rd_arbiter #(.ADDR_WID(16), .DATA_WID(32), .RD_LAT(3), .WAIT_WID(16)) dut3 (
        .clk(clk), .rst(rst), .acc_ren(a3_ren), .acc_raddr(a3_addr), .acc_rdata(d3_acc_rdata),
        .acc_rvalid(d3_acc_rvalid), .host_req(h3_req), .host_addr(h3_addr), .host_gnt(d3_host_gnt),
        .host_rdata(d3_host_rdata), .host_rvalid(d3_host_rvalid), .bram_ren(d3_bram_ren), .bram_raddr(d3_bram_raddr),
        .bram_rdata(d3_bram_rdata), .host_wait(d3_host_wait));

    function automatic logic [31:0] mem(input logic [15:0] a);
        if (a == 16'h0010) return 32'hDEAD_BEEF;
        return {a ^ 16'h5A5A, a};
    endfunction

    // BRAM models: first stage loads on ren, later stages model extra read latency.
    logic [31:0] m3a, m3b;
    always @(posedge clk) begin
        if (bram_ren)    bram_rdata    <= mem(bram_raddr);
        if (d4_bram_ren) d4_bram_rdata <= mem(d4_bram_raddr);
        if (d3_bram_ren) m3a           <= mem(d3_bram_raddr);
        m3b           <= m3a;
        d3_bram_rdata <= m3b;
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int          acc_due[$], host_due[$], a3_due[$], h3_due[$];
    logic [31:0] acc_dat[$], host_dat[$], a3_dat[$], h3_dat[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check issue mux against expected grants, schedule returns, check returns due now.
    task automatic tick(input bit g, input bit g3);
        logic [15:0] ea;
        logic        ev;
        #1;
        ea = acc_ren ? acc_raddr : (g ? host_addr : 16'h0);
        chk("host_gnt", {31'b0, host_gnt}, {31'b0, g});
        chk("d4_host_gnt", {31'b0, d4_host_gnt}, {31'b0, g});
        chk("bram_ren", {31'b0, bram_ren}, {31'b0, acc_ren | g});
        chk("bram_raddr", {16'b0, bram_raddr}, {16'b0, ea});
        ea = a3_ren ? a3_addr : (g3 ? h3_addr : 16'h0);
        chk("d3_host_gnt", {31'b0, d3_host_gnt}, {31'b0, g3});
        chk("d3_bram_raddr", {16'b0, d3_bram_raddr}, {16'b0, ea});
        if (acc_ren) begin acc_due.push_back(cyc + L1); acc_dat.push_back(mem(acc_raddr)); end
        if (g)       begin host_due.push_back(cyc + L1); host_dat.push_back(mem(host_addr)); end
        if (a3_ren)  begin a3_due.push_back(cyc + L3); a3_dat.push_back(mem(a3_addr)); end
        if (g3)      begin h3_due.push_back(cyc + L3); h3_dat.push_back(mem(h3_addr)); end

        ev = (acc_due.size() > 0) && (acc_due[0] == cyc);
        chk("acc_rvalid", {31'b0, acc_rvalid}, {31'b0, ev});
        if (ev) begin chk("acc_rdata", acc_rdata, acc_dat.pop_front()); void'(acc_due.pop_front()); end
        ev = (host_due.size() > 0) && (host_due[0] == cyc);
        chk("host_rvalid", {31'b0, host_rvalid}, {31'b0, ev});
        if (ev) begin chk("host_rdata", host_rdata, host_dat.pop_front()); void'(host_due.pop_front()); end
        ev = (a3_due.size() > 0) && (a3_due[0] == cyc);
        chk("d3_acc_rvalid", {31'b0, d3_acc_rvalid}, {31'b0, ev});
        if (ev) begin chk("d3_acc_rdata", d3_acc_rdata, a3_dat.pop_front()); void'(a3_due.pop_front()); end
        ev = (h3_due.size() > 0) && (h3_due[0] == cyc);
        chk("d3_host_rvalid", {31'b0, d3_host_rvalid}, {31'b0, ev});
        if (ev) begin chk("d3_host_rdata", d3_host_rdata, h3_dat.pop_front()); void'(h3_due.pop_front()); end

        @(negedge clk);
        cyc++;
    endtask

    initial begin
        rst = 1'b1;
        acc_ren = 1'b0; acc_raddr = '0; host_req = 1'b0; host_addr = '0;
        a3_ren = 1'b0; a3_addr = '0; h3_req = 1'b0; h3_addr = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_acc_rvalid", {31'b0, acc_rvalid}, 32'h0);
        chk("rst_host_rvalid", {31'b0, host_rvalid}, 32'h0);
        chk("rst_bram_ren", {31'b0, bram_ren}, 32'h0);
        chk("rst_acc_rdata", acc_rdata, 32'h0);
        chk("rst_host_rdata", host_rdata, 32'h0);
        chk("rst_host_wait", {16'b0, host_wait}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Controller read returns DEADBEEF after the read latency
        acc_ren = 1'b1; acc_raddr = 16'h0010;
        tick(0, 0);
        acc_ren = 1'b0;
        repeat (L1 + 1) tick(0, 0);

        // Host read on idle port, then a second one to show FSM is back in IDLE
        host_req = 1'b1; host_addr = 16'h0020;
        tick(1, 0);
        host_req = 1'b0;
        repeat (L1) tick(0, 0);
        host_req = 1'b1; host_addr = 16'h0021;
        tick(1, 0);
        host_req = 1'b0;
        repeat (L1) tick(0, 0);
        #1 chk("host_wait_after_grants", {16'b0, host_wait}, 32'h0);
        @(negedge clk); cyc++;

        // Controller holds the port for 5 cycles while host waits
        host_req = 1'b1; host_addr = 16'h0060;
        for (int i = 0; i < 5; i++) begin
            acc_ren = 1'b1; acc_raddr = 16'h0050 + 16'(i);
            #1 chk("host_wait_ramp", {16'b0, host_wait}, 32'(i));
            tick(0, 0);
        end
        acc_ren = 1'b0;
        #1 chk("host_wait_5", {16'b0, host_wait}, 32'd5);
        tick(1, 0);
        host_req = 1'b0;
        repeat (L1 + 1) tick(0, 0);

        // Host request withdrawn while pending: no issue, then fresh grant
        acc_ren = 1'b1; acc_raddr = 16'h00A0; host_req = 1'b1; host_addr = 16'h00B0;
        tick(0, 0);
        acc_ren = 1'b0; host_req = 1'b0;
        tick(0, 0);
        host_req = 1'b1; host_addr = 16'h00B1;
        tick(1, 0);
        host_req = 1'b0;
        repeat (L1 + 1) tick(0, 0);

        // RD_LAT=3 instance: acc, host, acc, acc back-to-back
        a3_ren = 1'b1; a3_addr = 16'h0030;
        tick(0, 0);
        a3_ren = 1'b0; h3_req = 1'b1; h3_addr = 16'h0040;
        tick(0, 1);
        h3_req = 1'b0; a3_ren = 1'b1; a3_addr = 16'h0031;
        tick(0, 0);
        a3_addr = 16'h0032;
        tick(0, 0);
        a3_ren = 1'b0;
        repeat (L3 + 1) tick(0, 0);
        h3_req = 1'b1; h3_addr = 16'h0041;
        tick(0, 1);
        h3_req = 1'b0;
        repeat (L3 + 1) tick(0, 0);

        // Reset one cycle after a host grant discards the in-flight read
        host_req = 1'b1; host_addr = 16'h0070;
        tick(1, 0);
        host_req = 1'b0; rst = 1'b1;
        host_due.delete(); host_dat.delete();
        tick(0, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_host_wait", {16'b0, host_wait}, 32'h0);
        chk("post_rst_acc_rdata", acc_rdata, 32'h0);
        chk("post_rst_host_rdata", host_rdata, 32'h0);
        repeat (L1 + 2) tick(0, 0);

        // Saturating wait counter: 20 stalled cycles
        host_req = 1'b1; host_addr = 16'h0080;
        for (int i = 0; i < 20; i++) begin
            acc_ren = 1'b1; acc_raddr = 16'h0090 + 16'(i);
            tick(0, 0);
        end
        acc_ren = 1'b0;
        #1;
        chk("host_wait_20", {16'b0, host_wait}, 32'd20);
        chk("host_wait_sat", {28'b0, d4_host_wait}, 32'd15);
        tick(1, 0);
        host_req = 1'b0;
        repeat (L1 + 2) tick(0, 0);
        #1 chk("host_wait_hold", {28'b0, d4_host_wait}, 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
